id_ex_stage: RTL and testbench

- Decode-to-execute pipeline register with operand forwarding. It sits directly upstream of the ALU and drives operand1, operand2, func3 and subsra.
- Captures register-file operands, the immediate and control fields from decode, resolves data hazards against the EX/MEM and MEM/WB result buses, and presents the resolved operands to the ALU.
- Valid/ready handshake on both sides; flush input for branch/trap redirect.

---
 rtl/id_ex_stage.sv | 203 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with operand forwarding.
//
// Holds one decoded instruction between decode and the ALU. A new entry is
// accepted on the rising edge when in_valid && in_ready && !flush. The held
// source operands are resolved against the EX/MEM and MEM/WB result buses
// before they are presented to the ALU.
//
// Configuration macro: ID_EX_FWD_EN
//   defined   - EX/MEM and MEM/WB forwarding, stall refresh and capture bypass
//   undefined - forwarding buses ignored, operands come from held RF values
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   flush                         drop held and incoming entry this cycle
//   in_valid / in_ready           decode-side handshake
//   in_rs1/rs2_addr, _data        source indices and register-file reads
//   in_imm, in_use_imm            immediate and operand2 select
//   in_func3, in_subsra           ALU control
//   in_rd_addr, in_reg_write      destination and write enable
//   exmem_we/rd/data              EX/MEM forwarding bus
//   memwb_we/rd/data              MEM/WB forwarding bus
//   out_valid / out_ready         execute-side handshake
//   operand1, operand2            resolved ALU operands
//   func3, subsra                 ALU control
//   rd_addr, reg_write            carried destination (reg_write gated by out_valid)

module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_AW-1:0] in_rs1_addr,
   input  logic [REG_AW-1:0] in_rs2_addr,
   input  logic [XLEN-1:0]   in_rs1_data,
   input  logic [XLEN-1:0]   in_rs2_data,
   input  logic [XLEN-1:0]   in_imm,
   input  logic              in_use_imm,
   input  logic [2:0]        in_func3,
   input  logic              in_subsra,
   input  logic [REG_AW-1:0] in_rd_addr,
   input  logic              in_reg_write,
   input  logic              exmem_we,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [XLEN-1:0]   exmem_data,
   input  logic              memwb_we,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [XLEN-1:0]   memwb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   operand1,
   output logic [XLEN-1:0]   operand2,
   output logic [2:0]        func3,
   output logic              subsra,
   output logic [REG_AW-1:0] rd_addr,
   output logic              reg_write
);

   logic              valid_q,    valid_d;
   logic [REG_AW-1:0] rs1_addr_q, rs1_addr_d;
   logic [REG_AW-1:0] rs2_addr_q, rs2_addr_d;
   logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
   logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
   logic [XLEN-1:0]   imm_q,      imm_d;
   logic              use_imm_q,  use_imm_d;
   logic [2:0]        func3_q,    func3_d;
   logic              subsra_q,   subsra_d;
   logic [REG_AW-1:0] rd_q,       rd_d;
   logic              regw_q,     regw_d;

   logic              accept;
   logic              stall;
   logic [XLEN-1:0]   fwdRs1;
   logic [XLEN-1:0]   fwdRs2;
   logic [XLEN-1:0]   capRs1;
   logic [XLEN-1:0]   capRs2;
   logic              refreshRs1;
   logic              refreshRs2;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready && !flush;
   assign stall    = valid_q && !out_ready;

`ifdef ID_EX_FWD_EN
   // EX/MEM beats MEM/WB; x0 is never forwarded.
   always_comb begin
      fwdRs1 = rs1_data_q;
      if (rs1_addr_q != '0 && exmem_we && exmem_rd == rs1_addr_q)
         fwdRs1 = exmem_data;
      else if (rs1_addr_q != '0 && memwb_we && memwb_rd == rs1_addr_q)
         fwdRs1 = memwb_data;
   end

   always_comb begin
      fwdRs2 = rs2_data_q;
      if (rs2_addr_q != '0 && exmem_we && exmem_rd == rs2_addr_q)
         fwdRs2 = exmem_data;
      else if (rs2_addr_q != '0 && memwb_we && memwb_rd == rs2_addr_q)
         fwdRs2 = memwb_data;
   end

   // The register file does not write through, so a MEM/WB write landing on
   // the capture cycle must be taken from the bus instead of the RF read.
   assign capRs1 = (in_rs1_addr != '0 && memwb_we && memwb_rd == in_rs1_addr)
                   ? memwb_data : in_rs1_data;
   assign capRs2 = (in_rs2_addr != '0 && memwb_we && memwb_rd == in_rs2_addr)
                   ? memwb_data : in_rs2_data;

   // A producer retiring while we stall would otherwise be lost once it
   // leaves the MEM/WB bus.
   assign refreshRs1 = stall && rs1_addr_q != '0 && memwb_we && memwb_rd == rs1_addr_q;
   assign refreshRs2 = stall && rs2_addr_q != '0 && memwb_we && memwb_rd == rs2_addr_q;
`else
   logic unused_fwd_bits;

   assign fwdRs1     = rs1_data_q;
   assign fwdRs2     = rs2_data_q;
   assign capRs1     = in_rs1_data;
   assign capRs2     = in_rs2_data;
   assign refreshRs1 = 1'b0;
   assign refreshRs2 = 1'b0;
   assign unused_fwd_bits = ^{exmem_we, exmem_rd, exmem_data,
                              memwb_we, memwb_rd, memwb_data};
`endif

   // Flush wins over capture and drain; fields are kept on flush since
   // nothing downstream looks at them while out_valid is low.
   always_comb begin
      valid_d    = valid_q;
      rs1_addr_d = rs1_addr_q;
      rs2_addr_d = rs2_addr_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      use_imm_d  = use_imm_q;
      func3_d    = func3_q;
      subsra_d   = subsra_q;
      rd_d       = rd_q;
      regw_d     = regw_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d    = 1'b1;
         rs1_addr_d = in_rs1_addr;
         rs2_addr_d = in_rs2_addr;
         rs1_data_d = capRs1;
         rs2_data_d = capRs2;
         imm_d      = in_imm;
         use_imm_d  = in_use_imm;
         func3_d    = in_func3;
         subsra_d   = in_subsra;
         rd_d       = in_rd_addr;
         regw_d     = in_reg_write;
      end else begin
         if (out_ready)
            valid_d = 1'b0;
         if (refreshRs1)
            rs1_data_d = memwb_data;
         if (refreshRs2)
            rs2_data_d = memwb_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         use_imm_q  <= 1'b0;
         func3_q    <= '0;
         subsra_q   <= 1'b0;
         rd_q       <= '0;
         regw_q     <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         use_imm_q  <= use_imm_d;
         func3_q    <= func3_d;
         subsra_q   <= subsra_d;
         rd_q       <= rd_d;
         regw_q     <= regw_d;
      end
   end

   assign out_valid = valid_q;
   assign operand1  = fwdRs1;
   assign operand2  = use_imm_q ? imm_q : fwdRs2;
   assign func3     = func3_q;
   assign subsra    = subsra_q;
   assign rd_addr   = rd_q;
   assign reg_write = regw_q && valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a behavioural model of the held instruction.

module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_rs1_addr = '0;
   logic [4:0]  in_rs2_addr = '0;
   logic [31:0] in_rs1_data = '0;
   logic [31:0] in_rs2_data = '0;
   logic [31:0] in_imm = '0;
   logic        in_use_imm = 1'b0;
   logic [2:0]  in_func3 = '0;
   logic        in_subsra = 1'b0;
   logic [4:0]  in_rd_addr = '0;
   logic        in_reg_write = 1'b0;
   logic        exmem_we = 1'b0;
   logic [4:0]  exmem_rd = '0;
   logic [31:0] exmem_data = '0;
   logic        memwb_we = 1'b0;
   logic [4:0]  memwb_rd = '0;
   logic [31:0] memwb_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] operand1;
   logic [31:0] operand2;
   logic [2:0]  func3;
   logic        subsra;
   logic [4:0]  rd_addr;
   logic        reg_write;

   int testsRun = 0;
   int testsFailed = 0;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] imm;
      logic        useImm;
      logic [2:0]  func3;
      logic        subsra;
      logic [4:0]  rd;
      logic        regWrite;
   } entry_t;

   entry_t model = '0;

`ifdef ID_EX_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_imm(in_imm), .in_use_imm(in_use_imm),
      .in_func3(in_func3), .in_subsra(in_subsra),
      .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
      .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
      .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .operand1(operand1), .operand2(operand2),
      .func3(func3), .subsra(subsra),
      .rd_addr(rd_addr), .reg_write(reg_write)
   );

   always #5 clk = ~clk;

   // Value a source operand must show: youngest in-flight result wins,
   // x0 is hard-wired, otherwise the value read at decode.
   function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] v);
      if (FWD && a != 0 && exmem_we && exmem_rd == a) return exmem_data;
      if (FWD && a != 0 && memwb_we && memwb_rd == a) return memwb_data;
      return v;
   endfunction

   // Value the held copy must contain after a MEM/WB write this cycle.
   function automatic logic [31:0] afterWriteback(input logic [4:0] a, input logic [31:0] v);
      if (FWD && a != 0 && memwb_we && memwb_rd == a) return memwb_data;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Compare every output against the model, then advance the model across
   // one rising edge using the inputs currently driven.
   task automatic stepCycle();
      entry_t nxt;
      logic   expReady;
      if (!rst_n) model = '0;
      expReady = !model.valid || out_ready;
      checkOutput("out_valid", 32'(out_valid), 32'(model.valid));
      checkOutput("in_ready", 32'(in_ready), 32'(expReady));
      checkOutput("reg_write", 32'(reg_write), 32'(model.valid & model.regWrite));
      if (model.valid) begin
         checkOutput("operand1", operand1, resolve(model.rs1, model.d1));
         checkOutput("operand2", operand2,
                     model.useImm ? model.imm : resolve(model.rs2, model.d2));
         checkOutput("func3", 32'(func3), 32'(model.func3));
         checkOutput("subsra", 32'(subsra), 32'(model.subsra));
         checkOutput("rd_addr", 32'(rd_addr), 32'(model.rd));
      end
      nxt = model;
      if (!rst_n) begin
         nxt = '0;
      end else if (flush) begin
         nxt.valid = 1'b0;
      end else if (in_valid && expReady) begin
         nxt.valid    = 1'b1;
         nxt.rs1      = in_rs1_addr;
         nxt.rs2      = in_rs2_addr;
         nxt.d1       = afterWriteback(in_rs1_addr, in_rs1_data);
         nxt.d2       = afterWriteback(in_rs2_addr, in_rs2_data);
         nxt.imm      = in_imm;
         nxt.useImm   = in_use_imm;
         nxt.func3    = in_func3;
         nxt.subsra   = in_subsra;
         nxt.rd       = in_rd_addr;
         nxt.regWrite = in_reg_write;
      end else if (model.valid && !out_ready) begin
         nxt.d1 = afterWriteback(model.rs1, model.d1);
         nxt.d2 = afterWriteback(model.rs2, model.d2);
      end else begin
         nxt.valid = 1'b0;
      end
      @(posedge clk);
      model = nxt;
      @(negedge clk);
   endtask

   task automatic idleBuses();
      in_valid = 1'b0; flush = 1'b0;
      exmem_we = 1'b0; exmem_rd = '0; exmem_data = '0;
      memwb_we = 1'b0; memwb_rd = '0; memwb_data = '0;
   endtask

   task automatic loadInstr(input logic [4:0] r1, input logic [31:0] v1,
                            input logic [4:0] r2, input logic [31:0] v2,
                            input logic ui, input logic [31:0] im,
                            input logic [2:0] f3, input logic ss, input logic [4:0] rd);
      in_valid = 1'b1;
      in_rs1_addr = r1; in_rs1_data = v1;
      in_rs2_addr = r2; in_rs2_data = v2;
      in_use_imm = ui; in_imm = im;
      in_func3 = f3; in_subsra = ss;
      in_rd_addr = rd; in_reg_write = 1'b1;
   endtask

   task automatic applyStimulus();
      in_valid     = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 9) == 0);
      out_ready    = ($urandom_range(0, 4) < 3);
      in_rs1_addr  = 5'($urandom_range(0, 3));
      in_rs2_addr  = 5'($urandom_range(0, 3));
      in_rs1_data  = $urandom;
      in_rs2_data  = $urandom;
      in_imm       = $urandom;
      in_use_imm   = 1'($urandom_range(0, 1));
      in_func3     = 3'($urandom_range(0, 7));
      in_subsra    = 1'($urandom_range(0, 1));
      in_rd_addr   = 5'($urandom_range(0, 31));
      in_reg_write = 1'($urandom_range(0, 1));
      exmem_we     = 1'($urandom_range(0, 1));
      exmem_rd     = 5'($urandom_range(0, 3));
      exmem_data   = $urandom;
      memwb_we     = 1'($urandom_range(0, 1));
      memwb_rd     = 5'($urandom_range(0, 3));
      memwb_data   = $urandom;
      #1;
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_operand1", operand1, 32'd0);
      checkOutput("reset_operand2", operand2, 32'd0);
      checkOutput("reset_reg_write", 32'(reg_write), 32'd0);
      stepCycle();
      rst_n = 1'b1;

      // Basic capture: 5 - 3 with SUB selected.
      out_ready = 1'b1;
      loadInstr(5'd1, 32'd5, 5'd2, 32'd3, 1'b0, 32'd0, 3'b000, 1'b1, 5'd4);
      #1; stepCycle();
      idleBuses(); #1;
      checkOutput("basic_valid", 32'(out_valid), 32'd1);
      checkOutput("basic_op1", operand1, 32'd5);
      checkOutput("basic_op2", operand2, 32'd3);
      checkOutput("basic_alu_sub", operand1 - operand2, 32'd2);
      checkOutput("basic_subsra", 32'(subsra), 32'd1);
      stepCycle();

      // Immediate path plus both buses hitting rs1.
      loadInstr(5'd7, 32'h55, 5'd0, 32'd0, 1'b1, 32'hFFFF_FFF0, 3'b000, 1'b0, 5'd8);
      #1; stepCycle();
      idleBuses(); out_ready = 1'b0;
      exmem_we = 1'b1; exmem_rd = 5'd7; exmem_data = 32'h100;
      memwb_we = 1'b1; memwb_rd = 5'd7; memwb_data = 32'h200;
      #1;
      checkOutput("prio_op1", operand1, FWD ? 32'h100 : 32'h55);
      checkOutput("prio_op2_imm", operand2, 32'hFFFF_FFF0);
      stepCycle();
      idleBuses(); out_ready = 1'b1; #1; stepCycle();

      // x0 is never forwarded even when a bus names it.
      loadInstr(5'd1, 32'd11, 5'd0, 32'd0, 1'b0, 32'd0, 3'b111, 1'b0, 5'd2);
      #1; stepCycle();
      idleBuses(); out_ready = 1'b0;
      exmem_we = 1'b1; exmem_rd = 5'd0; exmem_data = 32'hDEAD;
      #1;
      checkOutput("x0_guard_op2", operand2, 32'd0);
      stepCycle();
      idleBuses(); out_ready = 1'b1; #1; stepCycle();

      // Stall refresh from a retiring MEM/WB producer.
      loadInstr(5'd3, 32'd1, 5'd0, 32'd0, 1'b0, 32'd0, 3'b000, 1'b0, 5'd6);
      #1; stepCycle();
      idleBuses(); out_ready = 1'b0;
      memwb_we = 1'b1; memwb_rd = 5'd3; memwb_data = 32'd9;
      #1; stepCycle();
      idleBuses(); #1;
      checkOutput("refresh_op1", operand1, FWD ? 32'd9 : 32'd1);
      checkOutput("refresh_stalled_ready", 32'(in_ready), 32'd0);
      stepCycle();
      out_ready = 1'b1; #1;
      checkOutput("refresh_release_ready", 32'(in_ready), 32'd1);
      stepCycle();

      // Flush beats capture while stalled.
      out_ready = 1'b0;
      loadInstr(5'd1, 32'd1, 5'd2, 32'd2, 1'b0, 32'd0, 3'b001, 1'b0, 5'd5);
      #1; stepCycle();
      loadInstr(5'd1, 32'd7, 5'd2, 32'd8, 1'b0, 32'd0, 3'b010, 1'b0, 5'd9);
      flush = 1'b1;
      #1; stepCycle();
      idleBuses(); #1;
      checkOutput("flush_valid", 32'(out_valid), 32'd0);
      checkOutput("flush_not_captured_rd", 32'(rd_addr), 32'd5);
      stepCycle();

      // Asynchronous reset while holding a valid entry.
      out_ready = 1'b0;
      loadInstr(5'd2, 32'h1234, 5'd3, 32'h5678, 1'b0, 32'd0, 3'b100, 1'b1, 5'd10);
      #1; stepCycle();
      idleBuses(); #1;
      checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_valid", 32'(out_valid), 32'd0);
      checkOutput("async_reset_op1", operand1, 32'd0);
      checkOutput("async_reset_op2", operand2, 32'd0);
      stepCycle();
      rst_n = 1'b1;

      for (int i = 0; i < 2000; i++) begin
         applyStimulus();
         stepCycle();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
